// File: rtl/ttl491_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ttl491_sweep_ctrl
//
// Drives an external 74x491-style loadable up/down counter through a
// sawtooth or triangle sweep between two endpoints. A sweep can repeat a
// configured number of times, or indefinitely until it is aborted.
//
// The counter controls (SET, LD_n, CNT_n, UP_n) are decoded combinationally
// from the state, the live counter value Q and the latched sweep settings.
// The enable therefore drops in the same cycle that Q reaches its target,
// and the counter never overshoots an endpoint.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset; also forces idle outputs
//              combinationally while it is low
//   start      begin a sweep (sampled only in IDLE)
//   abort      stop the running sweep immediately (ignored in IDLE)
//   cfg_start  sweep start value
//   cfg_end    sweep end value
//   cfg_bounce 0 = sawtooth (reload each pass), 1 = triangle
//   cfg_loops  number of passes, 0 = run until abort
//   cfg_park   1 = set the counter to all-ones when the sweep completes
//   Q          current counter value
//   SET        counter preset to all-ones
//   LD_n       counter parallel load, active low
//   CNT_n      counter count enable, active low
//   UP_n       counter direction: 0 = up, 1 = down
//   D          counter load value (always the latched start value)
//   busy       high whenever a sweep is in progress
//   done       one-cycle pulse on normal completion
//   aborted    one-cycle pulse when a sweep is aborted
//   loop_cnt   passes completed in the current sweep
// ----------------------------------------------------------------------------
module ttl491_sweep_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int LOOP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] cfg_start,
    input  logic [DATA_WIDTH-1:0] cfg_end,
    input  logic                  cfg_bounce,
    input  logic [LOOP_WIDTH-1:0] cfg_loops,
    input  logic                  cfg_park,
    input  logic [DATA_WIDTH-1:0] Q,
    output logic                  SET,
    output logic                  LD_n,
    output logic                  CNT_n,
    output logic                  UP_n,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LOOP_WIDTH-1:0] loop_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN_FWD = 3'd2,
        RUN_REV = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sweep settings captured when a sweep starts; cfg_* changes while busy
    // have no influence on the running sweep.
    logic [DATA_WIDTH-1:0] start_s;
    logic [DATA_WIDTH-1:0] end_s;
    logic                  bounce_s;
    logic [LOOP_WIDTH-1:0] loops_s;
    logic                  park_s;
    logic [LOOP_WIDTH-1:0] loop_cnt_q;

    logic                  dir_up;
    logic                  at_end;
    logic                  at_start;
    logic                  last_pass;
    logic [LOOP_WIDTH-1:0] loop_cnt_inc;
    logic                  pass_end;
    logic                  latch_cfg;

    // Direction comes from an unsigned compare of the endpoints, so the
    // counter always moves the short way between them and never wraps.
    assign dir_up   = (end_s >= start_s);
    assign at_end   = (Q == end_s);
    assign at_start = (Q == start_s);

    // A pass is the last one only in a bounded sweep; in a free-running
    // sweep the pass counter sticks at all-ones rather than wrapping.
    assign last_pass    = (loops_s != '0) &&
                          ((loop_cnt_q + LOOP_WIDTH'(1)) == loops_s);
    assign loop_cnt_inc = ((loops_s == '0) && (&loop_cnt_q)) ?
                          loop_cnt_q : (loop_cnt_q + LOOP_WIDTH'(1));

    assign D        = start_s;
    assign loop_cnt = loop_cnt_q;
    assign busy     = rst_n && (state != IDLE);

    always_comb begin
        state_nxt = state;
        SET       = 1'b0;
        LD_n      = 1'b1;
        CNT_n     = 1'b1;
        UP_n      = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        pass_end  = 1'b0;
        latch_cfg = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                LD_n      = 1'b0;
                state_nxt = RUN_FWD;
            end
            RUN_FWD: begin
                UP_n = !dir_up;
                if (!at_end) begin
                    CNT_n = 1'b0;
                end else if (bounce_s) begin
                    state_nxt = RUN_REV;
                end else begin
                    pass_end = 1'b1;
                end
            end
            RUN_REV: begin
                UP_n = dir_up;
                if (!at_start) begin
                    CNT_n = 1'b0;
                end else begin
                    pass_end = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                SET       = park_s;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A triangle pass ends with the counter already sitting on the start
        // value, so it can go straight back to counting without a reload.
        if (pass_end) begin
            if (last_pass) begin
                state_nxt = DONE;
            end else if (bounce_s) begin
                state_nxt = RUN_FWD;
            end else begin
                state_nxt = LOAD;
            end
        end

        // Abort overrides everything, including a pass ending this cycle.
        if ((state != IDLE) && abort) begin
            SET       = 1'b0;
            LD_n      = 1'b1;
            CNT_n     = 1'b1;
            done      = 1'b0;
            aborted   = 1'b1;
            pass_end  = 1'b0;
            state_nxt = IDLE;
        end

        // Reset holds the counter still in the very cycle it is asserted.
        if (!rst_n) begin
            SET       = 1'b0;
            LD_n      = 1'b1;
            CNT_n     = 1'b1;
            UP_n      = 1'b0;
            done      = 1'b0;
            aborted   = 1'b0;
            pass_end  = 1'b0;
            latch_cfg = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_s    <= '0;
            end_s      <= '0;
            bounce_s   <= 1'b0;
            loops_s    <= '0;
            park_s     <= 1'b0;
            loop_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (latch_cfg) begin
                start_s    <= cfg_start;
                end_s      <= cfg_end;
                bounce_s   <= cfg_bounce;
                loops_s    <= cfg_loops;
                park_s     <= cfg_park;
                loop_cnt_q <= '0;
            end else if (pass_end) begin
                loop_cnt_q <= loop_cnt_inc;
            end
        end
    end

endmodule
